// File: rtl/dca_matrix_lsu_arbiter.sv
// ----------------------------------------------------------------------------
// dca_matrix_lsu_arbiter
//
// Purpose
//   Shares one LSU instruction port among four requesters: three matrix-register
//   loads (A/B/C, ids 0..2) and one store (id 3). Instructions are picked
//   round-robin and issued through a one-entry output stage. The ids of
//   outstanding loads are kept in an in-order FIFO. Row data coming back from
//   the LSU is routed to the load requester at the FIFO head.
//
// Ports
//   clk, rstnn              clock (rising edge), asynchronous active-low reset
//   clear                   synchronous flush of stage, FIFO, pointer and err
//   enable                  global advance enable; when low all state holds
//   busy                    stage valid or loads outstanding
//   req_valid/ready/inst    four instruction requesters, packed BW_INST each
//   lsu_inst_*              issued instruction plus the id of its requester
//   lsu_load_w*             row return stream from the LSU
//   ld_w*                   row stream fanned out to load requesters
//   err                     sticky: LSU row arrived with no outstanding load
//
// Handshake rule used on every valid/ready pair in this block: a transfer
// happens on a rising edge where valid and ready are both 1. A source keeps
// valid and payload stable until that transfer. Ready may depend
// combinationally on valid, but valid never depends on ready.
// ----------------------------------------------------------------------------
module dca_matrix_lsu_arbiter #(
  parameter int BW_INST = 64,
  parameter int BW_ROW  = 256,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 clear,
  input  logic                 enable,
  output logic                 busy,

  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [4*BW_INST-1:0] req_inst,

  output logic                 lsu_inst_valid,
  input  logic                 lsu_inst_ready,
  output logic [BW_INST-1:0]   lsu_inst,
  output logic [1:0]           lsu_inst_id,

  input  logic                 lsu_load_wvalid,
  output logic                 lsu_load_wready,
  input  logic                 lsu_load_wlast,
  input  logic [BW_ROW-1:0]    lsu_load_wdata,

  output logic [2:0]           ld_wvalid,
  input  logic [2:0]           ld_wready,
  output logic                 ld_wlast,
  output logic [BW_ROW-1:0]    ld_wdata,

  output logic                 err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic               stage_valid_q, stage_valid_d;
  logic [BW_INST-1:0] stage_inst_q,  stage_inst_d;
  logic [1:0]         stage_id_q,    stage_id_d;
  logic [1:0]         ptr_q,         ptr_d;
  logic [1:0]         fifo_mem_q [DEPTH];
  logic [1:0]         fifo_mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q,      rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [CNT_W-1:0]   count_q,       count_d;
  logic               err_q,         err_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       fifo_empty;
  logic       fifo_full;
  logic [1:0] head_id;
  logic       arb_en;
  logic [3:0] eligible;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [1:0] cand;
  logic       grant_fire;
  logic       push;
  logic       pop;
  logic       stage_fire;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head_id    = fifo_mem_q[rd_ptr_q];
  assign stage_fire = stage_valid_q & lsu_inst_ready;

  // The stage can take a new instruction when it is empty or being drained.
  assign arb_en = enable & ~clear & (~stage_valid_q | lsu_inst_ready);

  // Loads are held off while the FIFO is full. A pop in the same cycle
  // does not lift the block: this keeps ready independent of the
  // LSU return path.
  assign eligible = req_valid & {1'b1, {3{~fifo_full}}};

  // Round-robin search, starting at ptr_q and ascending modulo 4.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 2'd0;
    cand        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign grant_fire = arb_en & grant_valid;
  assign push       = grant_fire & (grant_id != 2'd3);

  // Requesters see nothing while reset is held. This keeps every output
  // at zero even though req_valid may already be high.
  always_comb begin
    req_ready = 4'b0000;
    if (rstnn && grant_fire) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Return-path routing to the load at the FIFO head.
  always_comb begin
    ld_wvalid = 3'b000;
    if (!fifo_empty) begin
      ld_wvalid[head_id] = lsu_load_wvalid;
    end
  end

  assign lsu_load_wready = enable & ~fifo_empty & ld_wready[head_id];
  assign ld_wlast        = rstnn & lsu_load_wlast;
  assign ld_wdata        = rstnn ? lsu_load_wdata : '0;

  // lsu_load_wready already implies enable and a non-empty FIFO.
  assign pop = lsu_load_wvalid & lsu_load_wready & lsu_load_wlast;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_inst_d  = stage_inst_q;
    stage_id_d    = stage_id_q;
    ptr_d         = ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    err_d         = err_q;
    for (int i = 0; i < DEPTH; i++) begin
      fifo_mem_d[i] = fifo_mem_q[i];
    end

    if (clear) begin
      stage_valid_d = 1'b0;
      stage_inst_d  = '0;
      stage_id_d    = 2'd0;
      ptr_d         = 2'd0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      err_d         = 1'b0;
    end else if (enable) begin
      // Output stage: a new grant overwrites an accepted entry. An accepted
      // entry with no grant behind it empties the stage.
      if (grant_fire) begin
        stage_valid_d = 1'b1;
        stage_inst_d  = req_inst[grant_id*BW_INST +: BW_INST];
        stage_id_d    = grant_id;
        ptr_d         = grant_id + 2'd1;
      end else if (stage_fire) begin
        stage_valid_d = 1'b0;
      end

      if (push) begin
        fifo_mem_d[wr_ptr_q] = grant_id;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (lsu_load_wvalid && fifo_empty) begin
        err_d = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      stage_valid_q <= 1'b0;
      stage_inst_q  <= '0;
      stage_id_q    <= 2'd0;
      ptr_q         <= 2'd0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_q[i] <= 2'd0;
      end
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_inst_q  <= stage_inst_d;
      stage_id_q    <= stage_id_d;
      ptr_q         <= ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      err_q         <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign lsu_inst_valid = stage_valid_q;
  assign lsu_inst       = stage_inst_q;
  assign lsu_inst_id    = stage_id_q;
  assign busy           = stage_valid_q | ~fifo_empty;
  assign err            = err_q;

endmodule

// File: tb/tb_dca_matrix_lsu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dca_matrix_lsu_arbiter
//
// Directed bench for dca_matrix_lsu_arbiter. Inputs are driven on the falling
// edge. Outputs are sampled 1 ns later, which is well away from the rising
// edge that commits state.
// ----------------------------------------------------------------------------
module tb_dca_matrix_lsu_arbiter;

  localparam int BW_INST = 16;
  localparam int BW_ROW  = 32;
  localparam int DEPTH   = 4;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  logic                 clear;
  logic                 enable;
  logic                 busy;
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  logic [4*BW_INST-1:0] req_inst;
  logic                 lsu_inst_valid;
  logic                 lsu_inst_ready;
  logic [BW_INST-1:0]   lsu_inst;
  logic [1:0]           lsu_inst_id;
  logic                 lsu_load_wvalid;
  logic                 lsu_load_wready;
  logic                 lsu_load_wlast;
  logic [BW_ROW-1:0]    lsu_load_wdata;
  logic [2:0]           ld_wvalid;
  logic [2:0]           ld_wready;
  logic                 ld_wlast;
  logic [BW_ROW-1:0]    ld_wdata;
  logic                 err;

  dca_matrix_lsu_arbiter #(
    .BW_INST(BW_INST),
    .BW_ROW (BW_ROW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rstnn          (rstnn),
    .clear          (clear),
    .enable         (enable),
    .busy           (busy),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_inst       (req_inst),
    .lsu_inst_valid (lsu_inst_valid),
    .lsu_inst_ready (lsu_inst_ready),
    .lsu_inst       (lsu_inst),
    .lsu_inst_id    (lsu_inst_id),
    .lsu_load_wvalid(lsu_load_wvalid),
    .lsu_load_wready(lsu_load_wready),
    .lsu_load_wlast (lsu_load_wlast),
    .lsu_load_wdata (lsu_load_wdata),
    .ld_wvalid      (ld_wvalid),
    .ld_wready      (ld_wready),
    .ld_wlast       (ld_wlast),
    .ld_wdata       (ld_wdata),
    .err            (err)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each requester's instruction is 16'h1111 * (id + 1).
  function automatic logic [BW_INST-1:0] inst_of(input logic [1:0] id);
    logic [BW_INST-1:0] r;
    case (id)
      2'd0:    r = 16'h1111;
      2'd1:    r = 16'h2222;
      2'd2:    r = 16'h3333;
      default: r = 16'h4444;
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rstnn = 1'b0;
    step();
    step();
    rstnn = 1'b1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic drive_row(input logic v, input logic last, input logic [2:0] rdy,
                           input logic [BW_ROW-1:0] data);
    lsu_load_wvalid = v;
    lsu_load_wlast  = last;
    ld_wready       = rdy;
    lsu_load_wdata  = data;
  endtask

  logic [3:0]        rr_ready [5];
  logic [1:0]        rr_id    [5];
  int                route_len [2];
  logic [BW_ROW-1:0] row;

  initial begin
    rr_ready  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_id     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    route_len = '{2, 3};

    clear          = 1'b0;
    enable         = 1'b1;
    req_valid      = 4'b1111;
    req_inst       = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    lsu_inst_ready = 1'b0;
    drive_row(1'b1, 1'b1, 3'b111, 32'hDEAD_BEEF);

    // ---------------- Reset: every output is zero, even with inputs active
    @(negedge clk);
    settle();
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_inst_valid", lsu_inst_valid, 1'b0);
    check("rst_inst", lsu_inst, '0);
    check("rst_inst_id", lsu_inst_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ld_wvalid", ld_wvalid, 3'b000);
    check("rst_wready", lsu_load_wready, 1'b0);
    check("rst_ld_wdata", ld_wdata, '0);
    check("rst_ld_wlast", ld_wlast, 1'b0);
    drive_row(1'b0, 1'b0, 3'b000, '0);
    req_valid = 4'b0000;
    do_reset();

    // ---------------- Round robin with all four requesting
    req_valid      = 4'b1111;
    lsu_inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("rr_ready", req_ready, rr_ready[i]);
      if (i > 0) begin
        check("rr_valid", lsu_inst_valid, 1'b1);
        check("rr_id", lsu_inst_id, exp_q[0]);
        check("rr_inst", lsu_inst, inst_of(exp_q[0]));
        void'(exp_q.pop_front());
      end
      exp_q.push_back(rr_id[i]);
      step();
    end
    req_valid = 4'b0000;
    settle();
    check("rr_last_id", lsu_inst_id, exp_q[0]);
    check("rr_last_inst", lsu_inst, inst_of(exp_q[0]));
    void'(exp_q.pop_front());
    step();
    settle();
    check("rr_drained", lsu_inst_valid, 1'b0);
    check("rr_busy_fifo", busy, 1'b1);

    // ---------------- FIFO full (holds 0,1,2,0, ptr=1): only the store wins
    req_valid = 4'b1001;
    settle();
    check("full_store_grant", req_ready, 4'b1000);
    step();
    settle();
    check("full_store_id", lsu_inst_id, 2'd3);
    req_valid = 4'b0001;
    drive_row(1'b1, 1'b1, 3'b111, 32'h0000_00A0);
    settle();
    check("full_blocked_on_pop", req_ready, 4'b0000);
    check("full_pop_route", ld_wvalid, 3'b001);
    check("full_pop_wready", lsu_load_wready, 1'b1);
    step();
    drive_row(1'b0, 1'b0, 3'b111, '0);
    settle();
    check("full_after_pop_grant", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    settle();
    check("full_load_id", lsu_inst_id, 2'd0);
    check("full_load_inst", lsu_inst, 16'h1111);
    pulse_clear();
    settle();
    check("clear_busy", busy, 1'b0);
    check("clear_inst_valid", lsu_inst_valid, 1'b0);

    // ---------------- Backpressure: stage holds id 2 for five cycles
    req_valid      = 4'b0100;
    lsu_inst_ready = 1'b0;
    settle();
    check("bp_grant2", req_ready, 4'b0100);
    step();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp_ready_low", req_ready, 4'b0000);
      check("bp_valid", lsu_inst_valid, 1'b1);
      check("bp_id", lsu_inst_id, 2'd2);
      check("bp_inst", lsu_inst, 16'h3333);
      step();
    end
    lsu_inst_ready = 1'b1;
    settle();
    check("bp_release_grant3", req_ready, 4'b1000);
    step();
    req_valid = 4'b0000;
    settle();
    check("bp_next_id", lsu_inst_id, 2'd3);
    step();
    settle();
    check("bp_drained", lsu_inst_valid, 1'b0);
    pulse_clear();

    // ---------------- Routing: loads issued as 1 then 0
    req_valid = 4'b0010;
    settle();
    check("rt_grant1", req_ready, 4'b0010);
    exp_q.push_back(2'd1);
    step();
    req_valid = 4'b0001;
    settle();
    check("rt_grant0", req_ready, 4'b0001);
    check("rt_id1", lsu_inst_id, 2'd1);
    exp_q.push_back(2'd0);
    step();
    req_valid = 4'b0000;
    settle();
    check("rt_id0", lsu_inst_id, 2'd0);
    step();
    // The head requester is not ready: nothing may be popped.
    drive_row(1'b1, 1'b1, 3'b101, 32'h5555_0000);
    settle();
    check("rt_stall_route", ld_wvalid, 3'b010);
    check("rt_stall_wready", lsu_load_wready, 1'b0);
    step();
    for (int l = 0; l < 2; l++) begin
      for (int r = 0; r < route_len[l]; r++) begin
        row = $urandom;
        drive_row(1'b1, (r == route_len[l] - 1), 3'b111, row);
        settle();
        check("rt_wvalid", ld_wvalid, 3'(1 << exp_q[0]));
        check("rt_wdata", ld_wdata, row);
        check("rt_wlast", ld_wlast, (r == route_len[l] - 1));
        check("rt_wready", lsu_load_wready, 1'b1);
        step();
      end
      void'(exp_q.pop_front());
    end
    drive_row(1'b0, 1'b0, 3'b111, '0);
    settle();
    check("rt_end_busy", busy, 1'b0);
    check("rt_end_wvalid", ld_wvalid, 3'b000);

    // ---------------- Push and pop in one cycle at occupancy 2 (ptr=1)
    req_valid = 4'b0011;
    settle();
    check("sim_grant1", req_ready, 4'b0010);
    step();
    settle();
    check("sim_grant0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0100;
    drive_row(1'b1, 1'b1, 3'b111, 32'h0000_0001);
    settle();
    check("sim_push_grant2", req_ready, 4'b0100);
    check("sim_pop_head1", ld_wvalid, 3'b010);
    step();
    req_valid = 4'b0000;
    settle();
    check("sim_next_head0", ld_wvalid, 3'b001);
    step();
    settle();
    check("sim_next_head2", ld_wvalid, 3'b100);
    check("sim_busy_last", busy, 1'b1);
    step();
    drive_row(1'b0, 1'b0, 3'b111, '0);
    settle();
    check("sim_end_busy", busy, 1'b0);

    // ---------------- Error when a row arrives with nothing outstanding
    drive_row(1'b1, 1'b0, 3'b111, 32'hBAD0_0000);
    settle();
    check("err_wready_low", lsu_load_wready, 1'b0);
    check("err_no_route", ld_wvalid, 3'b000);
    check("err_not_yet", err, 1'b0);
    step();
    drive_row(1'b0, 1'b0, 3'b111, '0);
    settle();
    check("err_set", err, 1'b1);
    step();
    settle();
    check("err_sticky", err, 1'b1);
    clear     = 1'b1;
    req_valid = 4'b1111;
    settle();
    check("clr_blocks_grant", req_ready, 4'b0000);
    step();
    clear = 1'b0;
    settle();
    check("clr_err", err, 1'b0);
    check("clr_busy", busy, 1'b0);
    check("clr_ptr0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    settle();
    check("clr_issue_id0", lsu_inst_id, 2'd0);
    step();

    // ---------------- enable low: no grants, no pops
    enable    = 1'b0;
    req_valid = 4'b1111;
    drive_row(1'b1, 1'b1, 3'b111, 32'h0000_0002);
    settle();
    check("en_ready_low", req_ready, 4'b0000);
    check("en_wready_low", lsu_load_wready, 1'b0);
    step();
    enable    = 1'b1;
    req_valid = 4'b0000;
    drive_row(1'b0, 1'b0, 3'b111, '0);
    settle();
    check("en_no_issue", lsu_inst_valid, 1'b0);
    check("en_held_busy", busy, 1'b1);
    drive_row(1'b1, 1'b1, 3'b111, 32'h0000_0003);
    settle();
    check("en_pop_wready", lsu_load_wready, 1'b1);
    step();
    drive_row(1'b0, 1'b0, 3'b111, '0);
    settle();
    check("en_end_busy", busy, 1'b0);

    // ---------------- Reset in the middle of a transfer (ptr=1)
    req_valid = 4'b0011;
    step();
    step();
    settle();
    check("mr_busy_before", busy, 1'b1);
    drive_row(1'b1, 1'b0, 3'b111, 32'h7777_7777);
    rstnn = 1'b0;
    settle();
    check("mr_req_ready", req_ready, 4'b0000);
    check("mr_inst_valid", lsu_inst_valid, 1'b0);
    check("mr_inst", lsu_inst, '0);
    check("mr_busy", busy, 1'b0);
    check("mr_ld_wvalid", ld_wvalid, 3'b000);
    check("mr_ld_wdata", ld_wdata, '0);
    step();
    req_valid = 4'b0000;
    drive_row(1'b0, 1'b0, 3'b111, '0);
    rstnn = 1'b1;
    step();
    settle();
    check("mr_no_residual_issue", lsu_inst_valid, 1'b0);
    check("mr_no_residual_busy", busy, 1'b0);
    drive_row(1'b1, 1'b1, 3'b111, 32'h0000_0004);
    settle();
    check("mr_no_residual_id", lsu_load_wready, 1'b0);
    check("mr_no_residual_route", ld_wvalid, 3'b000);
    step();
    drive_row(1'b0, 1'b0, 3'b000, '0);

    // ---------------- Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog: the directed sequence ends after a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
